// File: rtl/gpif_pkg.sv
// Shared definitions for the GPIFII slave-FIFO scheduler.
// Scheduler states, the read-port index and the DQ output mux codes.
package gpif_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_START   = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Port 0 is the only FX3->FPGA (read) port; it alone asserts SLOEn
    localparam logic [1:0] READ_PORT   = 2'd0;

    // DQ output mux codes for the outbound ports
    localparam logic [1:0] DP1_MUX_SEL = 2'd0;
    localparam logic [1:0] DP2_MUX_SEL = 2'd1;
    localparam logic [1:0] DP3_MUX_SEL = 2'd2;

    // Map an outbound port index to its DQ mux code
    function automatic logic [1:0] mux_sel_for(input logic [1:0] port);
        logic [1:0] sel;
        case (port)
            2'd1:    sel = DP1_MUX_SEL;
            2'd2:    sel = DP2_MUX_SEL;
            2'd3:    sel = DP3_MUX_SEL;
            default: sel = DP1_MUX_SEL;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpif_sched_if.sv
// Port-side bundle of the GPIFII scheduler.
// master = the scheduler, slave = the per-port FSMs and the FX3 pins it drives.
interface gpif_sched_if #(
    parameter int NPorts = 4
);
    logic [NPorts-1:0] en_i;
    logic [NPorts-1:0] req_i;
    logic [NPorts-1:0] done_i;
    logic [NPorts-1:0] strt_o;
    logic [NPorts-1:0] abort_o;
    logic [1:0]        SLADDR_o;
    logic              SLCSn_o;
    logic              SLOEn_o;
    logic [1:0]        dpoMuxSel_o;
    logic              busy_o;
    logic              wdog_err_o;

    modport master (
        input  en_i, req_i, done_i,
        output strt_o, abort_o, SLADDR_o, SLCSn_o, SLOEn_o,
               dpoMuxSel_o, busy_o, wdog_err_o
    );

    modport slave (
        output en_i, req_i, done_i,
        input  strt_o, abort_o, SLADDR_o, SLCSn_o, SLOEn_o,
               dpoMuxSel_o, busy_o, wdog_err_o
    );

endinterface

// File: rtl/gpif_sched_rr_arb.sv
// Combinational round-robin winner select.
// Scans the request vector circularly starting at ptr_i; the first set bit wins.
module rr_arb #(
    parameter int NPorts = 4
) (
    input  logic [NPorts-1:0] req_i,
    input  logic [1:0]        ptr_i,
    output logic [1:0]        idx_o,
    output logic              valid_o
);

    // Walk from the farthest offset back to ptr_i so the nearest request is written last
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = NPorts - 1; k >= 0; k--) begin
            int p;
            p = (int'(ptr_i) + k) % NPorts;
            if (req_i[p]) begin
                idx_o   = 2'(p);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpif_sched.sv
// Round-robin scheduler for the FX3 GPIFII slave-FIFO bus.
// Grants one port at a time, drives SLADDR/SLCSn/SLOEn and the DQ mux select,
// sequences start/done with the port FSMs and aborts transfers that hang in ACTIVE.
module gpif_sched
    import gpif_pkg::*;
#(
    parameter int NPorts    = 4,
    parameter int AddrTurn  = 3,
    parameter int WdogWidth = 16,
    parameter int WdogLimit = 40000
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    gpif_sched_if.master  bus
);

    // Scheduler state and bookkeeping
    state_e               state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;        // port owning the bus
    logic [1:0]           ptr_q, ptr_d;        // next search start = last strt port + 1
    logic [3:0]           settle_q, settle_d;  // SLADDR settle cycles spent in ADDR
    logic [WdogWidth-1:0] wdog_q, wdog_d;      // cycles spent in ACTIVE

    // Registered outputs
    logic [NPorts-1:0]    strt_q, strt_d;
    logic [NPorts-1:0]    abort_q, abort_d;
    logic [1:0]           sladdr_q, sladdr_d;
    logic                 slcsn_q, slcsn_d;
    logic                 sloen_q, sloen_d;
    logic [1:0]           mux_q, mux_d;
    logic                 busy_q, busy_d;
    logic                 werr_q, werr_d;

    // Arbitration over ports that both request and are enabled
    logic [NPorts-1:0]    elig;
    logic [1:0]           arb_idx;
    logic                 arb_valid;

    assign elig = bus.req_i & bus.en_i;

    rr_arb #(
        .NPorts (NPorts)
    ) u_rr_arb (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Next state and next output values; every output is a register fed from here
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        settle_d = settle_q;
        wdog_d   = wdog_q;
        strt_d   = '0;
        abort_d  = '0;
        sladdr_d = sladdr_q;
        slcsn_d  = 1'b1;
        sloen_d  = 1'b1;
        mux_d    = mux_q;
        werr_d   = werr_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d  = ST_ADDR;
                    gnt_d    = arb_idx;
                    sladdr_d = arb_idx;
                    settle_d = '0;
                    slcsn_d  = 1'b0;
                    sloen_d  = (arb_idx != READ_PORT);
                    // The mux keeps its last outbound code while the read port owns the bus
                    if (arb_idx != READ_PORT) begin
                        mux_d = mux_sel_for(arb_idx);
                    end
                end
            end

            ST_ADDR: begin
                slcsn_d = 1'b0;
                sloen_d = (gnt_q != READ_PORT);
                if (!bus.req_i[gnt_q] || !bus.en_i[gnt_q]) begin
                    // Port lost interest before the start pulse: give the bus back untouched
                    state_d = ST_RELEASE;
                    slcsn_d = 1'b1;
                    sloen_d = 1'b1;
                end else if (settle_q == 4'(AddrTurn)) begin
                    state_d        = ST_START;
                    strt_d[gnt_q]  = 1'b1;
                    wdog_d         = '0;
                    ptr_d          = (gnt_q == 2'(NPorts - 1)) ? 2'd0 : gnt_q + 2'd1;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            ST_START: begin
                state_d = ST_ACTIVE;
                slcsn_d = 1'b0;
                sloen_d = (gnt_q != READ_PORT);
                wdog_d  = '0;
            end

            ST_ACTIVE: begin
                slcsn_d = 1'b0;
                sloen_d = (gnt_q != READ_PORT);
                if (bus.done_i[gnt_q]) begin
                    // A done in the limit cycle still counts as a clean finish
                    state_d = ST_RELEASE;
                    slcsn_d = 1'b1;
                    sloen_d = 1'b1;
                end else if (wdog_q == WdogWidth'(WdogLimit - 1)) begin
                    state_d        = ST_RELEASE;
                    abort_d[gnt_q] = 1'b1;
                    werr_d         = 1'b1;
                    slcsn_d        = 1'b1;
                    sloen_d        = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, bookkeeping and output registers; reset puts the bus in its idle levels
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            settle_q <= '0;
            wdog_q   <= '0;
            strt_q   <= '0;
            abort_q  <= '0;
            sladdr_q <= '0;
            slcsn_q  <= 1'b1;
            sloen_q  <= 1'b1;
            mux_q    <= '0;
            busy_q   <= 1'b0;
            werr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            settle_q <= settle_d;
            wdog_q   <= wdog_d;
            strt_q   <= strt_d;
            abort_q  <= abort_d;
            sladdr_q <= sladdr_d;
            slcsn_q  <= slcsn_d;
            sloen_q  <= sloen_d;
            mux_q    <= mux_d;
            busy_q   <= busy_d;
            werr_q   <= werr_d;
        end
    end

    assign bus.strt_o      = strt_q;
    assign bus.abort_o     = abort_q;
    assign bus.SLADDR_o    = sladdr_q;
    assign bus.SLCSn_o     = slcsn_q;
    assign bus.SLOEn_o     = sloen_q;
    assign bus.dpoMuxSel_o = mux_q;
    assign bus.busy_o      = busy_q;
    assign bus.wdog_err_o  = werr_q;

endmodule

// File: tb/tb_gpif_sched.sv
// Self-checking bench for gpif_sched.
// A transaction-level model (round-robin pointer, expected mux code, sticky error)
// predicts each grant; cycle timing follows the documented latencies.
module tb_gpif_sched;

    localparam int NP = 4;
    localparam int AT = 3;
    localparam int WL = 20;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    gpif_sched_if #(.NPorts(NP)) bus ();

    gpif_sched #(
        .NPorts    (NP),
        .AddrTurn  (AT),
        .WdogWidth (16),
        .WdogLimit (WL)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         ptr_m;
    logic [1:0] mux_m;
    logic       werr_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int p);
        logic [3:0] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    // First eligible port at or after start, wrapping
    function automatic int winner(input logic [3:0] elig, input int start);
        for (int k = 0; k < NP; k++) begin
            if (elig[(start + k) % NP]) return (start + k) % NP;
        end
        return 0;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_strt"},  bus.strt_o,      0);
        check({tag, "_abort"}, bus.abort_o,     0);
        check({tag, "_addr"},  bus.SLADDR_o,    0);
        check({tag, "_csn"},   bus.SLCSn_o,     1);
        check({tag, "_oen"},   bus.SLOEn_o,     1);
        check({tag, "_mux"},   bus.dpoMuxSel_o, 0);
        check({tag, "_busy"},  bus.busy_o,      0);
        check({tag, "_werr"},  bus.wdog_err_o,  0);
    endtask

    // Called in an IDLE cycle with eligible requests; returns in the START cycle
    task automatic grant_to_start(output int p);
        p = winner(bus.req_i & bus.en_i, ptr_m);
        if (p != 0) mux_m = 2'(p - 1);
        tick();
        check("addr_sladdr", bus.SLADDR_o,    p);
        check("addr_csn",    bus.SLCSn_o,     0);
        check("addr_oen",    bus.SLOEn_o,     (p == 0) ? 0 : 1);
        check("addr_mux",    bus.dpoMuxSel_o, mux_m);
        check("addr_busy",   bus.busy_o,      1);
        for (int i = 0; i < AT; i++) begin
            tick();
            check("addr_nostrt",  bus.strt_o,   0);
            check("addr_stable",  bus.SLADDR_o, p);
        end
        tick();
        check("start_strt",   bus.strt_o,   oh(p));
        check("start_abort",  bus.abort_o,  0);
        check("start_sladdr", bus.SLADDR_o, p);
        ptr_m = (p + 1) % NP;
    endtask

    // From the START cycle: done for port p is high in cycle START+dly; returns in IDLE
    task automatic finish_done(input int p, input int dly, input logic [3:0] stray);
        for (int c = 1; c <= dly; c++) begin
            tick();
            check("act_csn",    bus.SLCSn_o, 0);
            check("act_oen",    bus.SLOEn_o, (p == 0) ? 0 : 1);
            check("act_pulse",  bus.strt_o | bus.abort_o, 0);
            check("act_werr",   bus.wdog_err_o, werr_m);
            if (c == dly)      bus.done_i = oh(p);
            else if (c == 1)   bus.done_i = stray & ~oh(p);
            else               bus.done_i = '0;
        end
        tick();
        bus.done_i = '0;
        check("rel_csn",   bus.SLCSn_o,  1);
        check("rel_oen",   bus.SLOEn_o,  1);
        check("rel_busy",  bus.busy_o,   1);
        check("rel_abort", bus.abort_o,  0);
        tick();
        check("idle_busy", bus.busy_o,   0);
        check("idle_csn",  bus.SLCSn_o,  1);
    endtask

    // From the START cycle: no done until the limit cycle (optionally done there); returns in IDLE
    task automatic finish_wdog(input int p, input bit tie);
        for (int c = 1; c <= WL; c++) begin
            tick();
            check("wd_csn",   bus.SLCSn_o, 0);
            check("wd_pulse", bus.strt_o | bus.abort_o, 0);
            bus.done_i = (tie && c == WL) ? oh(p) : 4'b0000;
        end
        tick();
        bus.done_i = '0;
        if (!tie) werr_m = 1'b1;
        check("wd_abort", bus.abort_o,    tie ? 4'b0000 : oh(p));
        check("wd_werr",  bus.wdog_err_o, werr_m);
        check("wd_csn_rel", bus.SLCSn_o,  1);
        tick();
        check("wd_abort_1cyc", bus.abort_o,    0);
        check("wd_werr_hold",  bus.wdog_err_o, werr_m);
        check("wd_idle_busy",  bus.busy_o,     0);
    endtask

    initial begin
        int p;
        int dly;
        logic [3:0] r_req;
        logic [3:0] r_en;

        rstn        = 1'b0;
        bus.en_i    = '0;
        bus.req_i   = '0;
        bus.done_i  = '0;
        ptr_m       = 0;
        mux_m       = 2'd0;
        werr_m      = 1'b0;

        tick();
        check_reset_vals("rst");
        tick();
        rstn = 1'b1;
        tick();
        check_reset_vals("idle");

        // Fairness: all ports requesting, done 5 cycles after each start
        bus.en_i  = 4'hF;
        bus.req_i = 4'hF;
        for (int g = 0; g < 5; g++) begin
            grant_to_start(p);
            finish_done(p, 5, 4'b0000);
        end

        // Single outbound request
        bus.req_i = 4'b0010;
        grant_to_start(p);
        finish_done(p, 3, 4'b0000);

        // Masked ports are never granted
        bus.en_i  = 4'b1010;
        bus.req_i = 4'hF;
        for (int g = 0; g < 4; g++) begin
            grant_to_start(p);
            finish_done(p, 2, 4'b0101);
        end

        // done arriving in the limit cycle beats the watchdog
        bus.en_i  = 4'hF;
        bus.req_i = 4'b0100;
        grant_to_start(p);
        finish_wdog(p, 1'b1);

        // Watchdog expiry on port 2
        grant_to_start(p);
        finish_wdog(p, 1'b0);

        // Random traffic with stray done pulses on other ports
        for (int g = 0; g < 12; g++) begin
            r_req = 4'($urandom_range(1, 15));
            r_en  = 4'($urandom_range(1, 15));
            if ((r_req & r_en) == 4'b0000) r_en = r_req;
            bus.req_i = r_req;
            bus.en_i  = r_en;
            dly = int'($urandom_range(1, 8));
            grant_to_start(p);
            finish_done(p, dly, 4'($urandom_range(0, 15)));
        end

        // Request dropped during ADDR: no start, one RELEASE cycle, pointer untouched
        bus.en_i  = 4'hF;
        bus.req_i = 4'b1000;
        mux_m     = 2'd2;
        tick();
        check("drop_sladdr", bus.SLADDR_o,    3);
        check("drop_mux",    bus.dpoMuxSel_o, mux_m);
        bus.req_i = 4'b0000;
        tick();
        check("drop_nostrt", bus.strt_o,  0);
        check("drop_csn",    bus.SLCSn_o, 1);
        check("drop_busy",   bus.busy_o,  1);
        tick();
        check("drop_idle",   bus.busy_o,  0);
        check("drop_nostrt2", bus.strt_o, 0);
        bus.req_i = 4'hF;
        grant_to_start(p);
        finish_done(p, 1, 4'b0000);

        // Asynchronous reset in ACTIVE: outputs return at once, pointer back to 0
        grant_to_start(p);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check_reset_vals("async_rst");
        ptr_m  = 0;
        mux_m  = 2'd0;
        werr_m = 1'b0;
        tick();
        rstn = 1'b1;
        bus.req_i = 4'hF;
        grant_to_start(p);
        finish_done(p, 2, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
